// File: rtl/tcdm_bank_arbiter_if.sv
// Requester-side and bank-side signal bundle for one TCDM bank arbiter.
// No logic and no latency; flow control is the req/gnt handshake carried inside.
// master = requesters plus bank model, slave = arbiter view.
interface tcdm_bank_arbiter_if #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32,
    parameter int BeWidth   = DataWidth / 8,
    parameter int IdWidth   = 1
);
    logic [NumReq-1:0]           req;
    logic [NumReq-1:0]           gnt;
    logic [NumReq*AddrWidth-1:0] add;
    logic [NumReq-1:0]           wen;
    logic [NumReq*DataWidth-1:0] data;
    logic [NumReq*BeWidth-1:0]   be;
    logic [NumReq*IdWidth-1:0]   id;
    logic [NumReq-1:0]           r_valid;
    logic [DataWidth-1:0]        r_data;
    logic [IdWidth-1:0]          r_id;
    logic                        bank_req;
    logic                        bank_gnt;
    logic [AddrWidth-1:0]        bank_add;
    logic                        bank_wen;
    logic [DataWidth-1:0]        bank_data;
    logic [BeWidth-1:0]          bank_be;
    logic [IdWidth-1:0]          bank_id;
    logic [DataWidth-1:0]        bank_r_data;

    modport master (
        output req, add, wen, data, be, id, bank_gnt, bank_r_data,
        input  gnt, r_valid, r_data, r_id,
               bank_req, bank_add, bank_wen, bank_data, bank_be, bank_id
    );

    modport slave (
        input  req, add, wen, data, be, id, bank_gnt, bank_r_data,
        output gnt, r_valid, r_data, r_id,
               bank_req, bank_add, bank_wen, bank_data, bank_be, bank_id
    );
endinterface

// File: rtl/tcdm_bank_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after the pointer, wrapping at NumReq-1.
// Purely combinational, zero latency; no backpressure (index 0, one-hot 0 when idle).
module tcdm_rr_pick #(
    parameter int NumReq   = 4,
    parameter int IdxWidth = 2
) (
    input  logic [NumReq-1:0]   i_req,
    input  logic [IdxWidth-1:0] i_ptr,
    output logic [NumReq-1:0]   o_onehot,
    output logic [IdxWidth-1:0] o_idx
);
    logic w_found;
    int   w_k;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        w_k      = 0;
        for (int i = 0; i < NumReq; i++) begin
            w_k = int'(i_ptr) + i;
            if (w_k >= NumReq) begin
                w_k = w_k - NumReq;
            end
            if (!w_found && i_req[w_k]) begin
                w_found       = 1'b1;
                o_onehot[w_k] = 1'b1;
                o_idx         = IdxWidth'(w_k);
            end
        end
    end
endmodule

// File: rtl/tcdm_bank_arbiter.sv
// Round-robin arbiter of NumReq requesters onto one single-ported TCDM bank.
// Grant is combinational; response valid/id one cycle after the handshake.
// Bank backpressure via bank_gnt_i: no grant and no state change while it is low.
module tcdm_bank_arbiter #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32,
    parameter int BeWidth   = DataWidth / 8,
    parameter int IdWidth   = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumReq-1:0]           req_i,
    output logic [NumReq-1:0]           gnt_o,
    input  logic [NumReq*AddrWidth-1:0] add_i,
    input  logic [NumReq-1:0]           wen_i,
    input  logic [NumReq*DataWidth-1:0] data_i,
    input  logic [NumReq*BeWidth-1:0]   be_i,
    input  logic [NumReq*IdWidth-1:0]   id_i,
    output logic [NumReq-1:0]           r_valid_o,
    output logic [DataWidth-1:0]        r_data_o,
    output logic [IdWidth-1:0]          r_id_o,
    output logic                        bank_req_o,
    input  logic                        bank_gnt_i,
    output logic [AddrWidth-1:0]        bank_add_o,
    output logic                        bank_wen_o,
    output logic [DataWidth-1:0]        bank_data_o,
    output logic [BeWidth-1:0]          bank_be_o,
    output logic [IdWidth-1:0]          bank_id_o,
    input  logic [DataWidth-1:0]        bank_r_data_i
);
    localparam int IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [IdxWidth-1:0] r_rr_q;
    logic [IdxWidth-1:0] r_pend_idx;
    logic                r_pend_vld;
    logic [IdWidth-1:0]  r_id;

    logic [NumReq-1:0]   w_onehot;
    logic [IdxWidth-1:0] w_idx;
    logic [IdxWidth-1:0] w_rr_nxt;
    logic                w_any;
    logic                w_hs;
    int                  w_sel;

    tcdm_rr_pick #(
        .NumReq   (NumReq),
        .IdxWidth (IdxWidth)
    ) u_rr_pick (
        .i_req    (req_i),
        .i_ptr    (r_rr_q),
        .o_onehot (w_onehot),
        .o_idx    (w_idx)
    );

    assign w_any      = |req_i;
    assign w_hs       = w_any & bank_gnt_i;
    assign bank_req_o = w_any;
    assign gnt_o      = w_onehot & {NumReq{bank_gnt_i}};
    assign w_rr_nxt   = (int'(w_idx) == NumReq - 1) ? '0 : w_idx + IdxWidth'(1);

    // The picker reports index 0 when idle, so the bank bus then mirrors requester 0.
    always_comb begin
        w_sel       = int'(w_idx);
        bank_add_o  = add_i [w_sel*AddrWidth +: AddrWidth];
        bank_wen_o  = wen_i [w_sel];
        bank_data_o = data_i[w_sel*DataWidth +: DataWidth];
        bank_be_o   = be_i  [w_sel*BeWidth   +: BeWidth];
        bank_id_o   = id_i  [w_sel*IdWidth   +: IdWidth];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_q     <= '0;
            r_pend_idx <= '0;
            r_pend_vld <= 1'b0;
            r_id       <= '0;
        end else begin
            r_pend_vld <= w_hs;
            if (w_hs) begin
                r_rr_q     <= w_rr_nxt;
                r_pend_idx <= w_idx;
                r_id       <= bank_id_o;
            end
        end
    end

    always_comb begin
        r_valid_o = '0;
        if (r_pend_vld) begin
            r_valid_o[r_pend_idx] = 1'b1;
        end
    end

    // Bank read data has exactly one cycle of latency, so it lines up with r_valid_o.
    assign r_data_o = bank_r_data_i;
    assign r_id_o   = r_id;
endmodule

// File: doc/tcdm_bank_arbiter.md
TCDM_BANK_ARBITER -- requirements
Module: tcdm_bank_arbiter

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- NumReq, 4, number of requesters (>=2).
- DataWidth, 32, data width.
- AddrWidth, 32, address width.
- BeWidth, DataWidth/8, byte-enable width.
- IdWidth, 1, transaction id width.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk_i, in, 1, clock.
- rst_ni, in, 1, asynchronous active-low reset.
- req_i, in, NumReq, per-requester request.
- gnt_o, out, NumReq, per-requester grant.
- add_i, in, NumReq*AddrWidth, packed addresses; slice k belongs to requester k.
- wen_i, in, NumReq, 1 = read, 0 = write.
- data_i, in, NumReq*DataWidth, write data.
- be_i, in, NumReq*BeWidth, byte enables.
- id_i, in, NumReq*IdWidth, transaction ids.
- r_valid_o, out, NumReq, per-requester response valid.
- r_data_o, out, DataWidth, read data, broadcast to all requesters.
- r_id_o, out, IdWidth, response id.
- bank_req_o, out, 1, bank request.
- bank_gnt_i, in, 1, bank grant.
- bank_add_o, out, AddrWidth, bank address.
- bank_wen_o, out, 1, bank wen; same polarity as wen_i.
- bank_data_o, out, DataWidth, bank write data.
- bank_be_o, out, BeWidth, bank byte enables.
- bank_id_o, out, IdWidth, bank id.
- bank_r_data_i, in, DataWidth, bank read data; 1-cycle latency.
REQ-003 SHALL use one clock, clk_i, and asynchronous active-low reset rst_ni.

Function
REQ-004 SHALL assert bank_req_o combinationally whenever any req_i bit is high.
REQ-005 SHALL select the winner combinationally by round-robin.
- Search starts at pointer rr_q and wraps from NumReq-1 to 0.
REQ-006 SHALL drive the bank_add/wen/data/be/id outputs from the winner's slices.
- With no request: these outputs are driven from requester 0 and bank_req_o is 0.
REQ-007 SHALL assert gnt_o[winner] = bank_gnt_i; all other gnt_o bits are 0.
- At most one gnt_o bit is high per cycle.
REQ-008 SHALL update rr_q on a handshake (bank_req_o & bank_gnt_i) to (winner+1) mod NumReq.
- rr_q holds when there is no handshake.
REQ-009 SHALL assert r_valid_o[w] for exactly one cycle, the cycle after a handshake for winner w.
- Applies to reads and writes alike.
REQ-010 SHALL drive r_data_o = bank_r_data_i combinationally and r_id_o = id registered at the handshake.
REQ-011 SHALL sustain back-to-back handshakes at one per cycle.
- r_valid_o for consecutive handshakes appears in consecutive cycles, in grant order.
REQ-012 SHALL give no grant and change no state while bank_gnt_i = 0.
- A response already pending still completes.
REQ-013 SHALL keep requests that are not granted pending (requester-held).
- A requester with req_i high is granted within NumReq handshakes.
REQ-014 SHALL handle pointer wrap: with rr_q = NumReq-1 and all requesting, grant NumReq-1, then 0.

Reset
REQ-015 SHALL, while rst_ni = 0, set rr_q = 0, r_valid_o = 0, r_id_o = 0 and the pending-winner register = 0.
REQ-016 SHALL drop any response pending at reset assertion: no r_valid_o after reset release.
REQ-017 SHALL keep gnt_o and bank_req_o combinational, so they follow req_i even in reset.

Structure
REQ-018 SHALL use no shared package.
- Requester index width $clog2(NumReq) is a local parameter.
REQ-019 SHALL place the round-robin picker in one combinational sub-module, tcdm_rr_pick.
- Inputs: req vector and pointer. Outputs: one-hot winner and index.

Verification
REQ-020 Reset, then req_i = 4'b1111 held, bank_gnt_i = 1 -> gnt_o = 0001, 0010, 0100, 1000, 0001; r_valid_o follows one cycle later in the same order.
REQ-021 Requester 2 reads addr 0x10 after requester 1 writes 0xDEADBEEF there with be = 4'hF -> r_data_o = 0xDEADBEEF with r_valid_o[2]; r_id_o equals id_i[2].
REQ-022 bank_gnt_i = 0 for 3 cycles with req_i = 0101 -> gnt_o = 0 and rr_q unchanged; on release, requester 0 is granted first.
REQ-023 rr_q = 3 with req_i = 1001 -> grant 3, then 0 (wrap).
REQ-024 rst_ni asserted the cycle after a handshake -> r_valid_o stays 0 and rr_q = 0 after release.
REQ-025 Random req_i and bank_gnt_i for 10k cycles -> no more than one gnt_o bit high per cycle; every handshake yields exactly one r_valid_o, to the correct requester; no requester waits more than NumReq handshakes.
